// File: rtl/grab_object_ctrl.sv
// Per-object slot controller feeding the grabbable-object renderer: spawn, grab, follow hook, score.
// Latency: spawn lands next cycle; grab/follow/collect commit on the cycle after startOfFrame.
// Backpressure: none; spawn is ignored while the object is grabbed or being collected.
module grab_object_ctrl #(
  parameter int OBJ_HALF_W   = 16,
  parameter int SCREEN_MAX_X = 608,
  parameter int SCREEN_MAX_Y = 448
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        spawn,
  input  logic [10:0] spawnX,
  input  logic [10:0] spawnY,
  input  logic [3:0]  spawnType,
  input  logic        collision,
  input  logic        hookBusy,
  input  logic [10:0] hookTipX,
  input  logic [10:0] hookTipY,
  input  logic        hookAtSurface,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [3:0]  objectType,
  output logic        grabbed,
  output logic [2:0]  pullWeight,
  output logic        scoreValid,
  output logic [7:0]  scoreValue
);

  localparam logic [10:0] MAX_X  = 11'(SCREEN_MAX_X);
  localparam logic [10:0] MAX_Y  = 11'(SCREEN_MAX_Y);
  localparam logic [10:0] HALF_W = 11'(OBJ_HALF_W);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_RESTING   = 2'd1,
    ST_GRABBED   = 2'd2,
    ST_COLLECTED = 2'd3
  } state_t;

  state_t      state_q;
  logic [10:0] x_q, y_q;
  logic [3:0]  type_q;
  logic        grabbed_q;
  logic [2:0]  weight_q;
  logic        score_vld_q;
  logic [7:0]  score_val_q;
  logic        coll_seen_q;

  logic [10:0] spawn_x_d, spawn_y_d;
  logic [10:0] follow_x_d, follow_y_d;
  logic [10:0] tip_off_x;
  logic        coll_eff;

  function automatic logic [7:0] score_of(input logic [3:0] t);
    case (t)
      4'd1:    score_of = 8'd50;
      4'd2:    score_of = 8'd100;
      4'd3:    score_of = 8'd250;
      4'd4:    score_of = 8'd10;
      default: score_of = 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] weight_of(input logic [3:0] t);
    case (t)
      4'd2:    weight_of = 3'd2;
      4'd3:    weight_of = 3'd3;
      4'd4:    weight_of = 3'd4;
      default: weight_of = 3'd1;
    endcase
  endfunction

  // Clamped spawn position and hook-following position candidates.
  always_comb begin
    spawn_x_d  = (spawnX > MAX_X) ? MAX_X : spawnX;
    spawn_y_d  = (spawnY > MAX_Y) ? MAX_Y : spawnY;
    tip_off_x  = hookTipX - HALF_W;
    follow_x_d = 11'd0;
    if (hookTipX >= HALF_W) begin
      follow_x_d = (tip_off_x > MAX_X) ? MAX_X : tip_off_x;
    end
    follow_y_d = (hookTipY > MAX_Y) ? MAX_Y : hookTipY;
  end

  // A collision anywhere in the frame, including the frame-start cycle itself, counts.
  assign coll_eff = coll_seen_q | collision;

  // Object slot state machine with registered renderer and hook outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_EMPTY;
      x_q         <= 11'd0;
      y_q         <= 11'd0;
      type_q      <= 4'd0;
      grabbed_q   <= 1'b0;
      weight_q    <= 3'd0;
      score_vld_q <= 1'b0;
      score_val_q <= 8'd0;
      coll_seen_q <= 1'b0;
    end else begin
      score_vld_q <= 1'b0;
      score_val_q <= 8'd0;
      if (startOfFrame) begin
        coll_seen_q <= 1'b0;
      end else if (collision) begin
        coll_seen_q <= 1'b1;
      end

      case (state_q)
        ST_EMPTY, ST_RESTING: begin
          if (spawn) begin
            // A fresh object discards any collision history of the old one.
            x_q         <= spawn_x_d;
            y_q         <= spawn_y_d;
            type_q      <= spawnType;
            coll_seen_q <= 1'b0;
            state_q     <= (spawnType != 4'd0) ? ST_RESTING : ST_EMPTY;
          end else if (state_q == ST_RESTING && startOfFrame && coll_eff && !hookBusy) begin
            // Position starts tracking the hook from the next frame.
            state_q   <= ST_GRABBED;
            grabbed_q <= 1'b1;
            weight_q  <= weight_of(type_q);
          end
        end
        ST_GRABBED: begin
          if (startOfFrame) begin
            if (hookAtSurface) begin
              state_q     <= ST_COLLECTED;
              grabbed_q   <= 1'b0;
              weight_q    <= 3'd0;
              score_vld_q <= 1'b1;
              score_val_q <= score_of(type_q);
            end else begin
              x_q <= follow_x_d;
              y_q <= follow_y_d;
            end
          end
        end
        ST_COLLECTED: begin
          state_q   <= ST_EMPTY;
          type_q    <= 4'd0;
          grabbed_q <= 1'b0;
          weight_q  <= 3'd0;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign topLeftX   = x_q;
  assign topLeftY   = y_q;
  assign objectType = (state_q == ST_EMPTY) ? 4'd0 : type_q;
  assign grabbed    = grabbed_q;
  assign pullWeight = weight_q;
  assign scoreValid = score_vld_q;
  assign scoreValue = score_val_q;

endmodule

// File: tb/tb_grab_object_ctrl.sv
// Directed vector bench for grab_object_ctrl: a table of one-cycle input/expected-output records
// plus hand-written reset sequences. Inputs change #1 after the rising edge; outputs are checked there.
module tb_grab_object_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame, spawn, collision, hookBusy, hookAtSurface;
  logic [10:0] spawnX, spawnY, hookTipX, hookTipY;
  logic [3:0]  spawnType;
  logic [10:0] topLeftX, topLeftY;
  logic [3:0]  objectType;
  logic        grabbed, scoreValid;
  logic [2:0]  pullWeight;
  logic [7:0]  scoreValue;

  int checks   = 0;
  int failures = 0;

  grab_object_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .spawn(spawn),
    .spawnX(spawnX), .spawnY(spawnY), .spawnType(spawnType), .collision(collision),
    .hookBusy(hookBusy), .hookTipX(hookTipX), .hookTipY(hookTipY),
    .hookAtSurface(hookAtSurface), .topLeftX(topLeftX), .topLeftY(topLeftY),
    .objectType(objectType), .grabbed(grabbed), .pullWeight(pullWeight),
    .scoreValid(scoreValid), .scoreValue(scoreValue)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sp;
    logic [10:0] sx, sy;
    logic [3:0]  st;
    logic        sof, col, busy;
    logic [10:0] tx, ty;
    logic        surf;
    logic [10:0] ex, ey;
    logic [3:0]  et;
    logic        eg;
    logic [2:0]  epw;
    logic        esv;
    logic [7:0]  esval;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int sp, int sx, int sy, int st, int sof, int col, int busy,
                              int tx, int ty, int surf,
                              int ex, int ey, int et, int eg, int epw, int esv, int esval);
    vec_t v;
    v.sp = 1'(sp);  v.sx = 11'(sx); v.sy = 11'(sy); v.st = 4'(st);
    v.sof = 1'(sof); v.col = 1'(col); v.busy = 1'(busy);
    v.tx = 11'(tx); v.ty = 11'(ty); v.surf = 1'(surf);
    v.ex = 11'(ex); v.ey = 11'(ey); v.et = 4'(et); v.eg = 1'(eg);
    v.epw = 3'(epw); v.esv = 1'(esv); v.esval = 8'(esval);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int ex, input int ey, input int et,
                         input int eg, input int epw, input int esv, input int esval);
    chk({tag, ".topLeftX"},   int'(topLeftX),   ex);
    chk({tag, ".topLeftY"},   int'(topLeftY),   ey);
    chk({tag, ".objectType"}, int'(objectType), et);
    chk({tag, ".grabbed"},    int'(grabbed),    eg);
    chk({tag, ".pullWeight"}, int'(pullWeight), epw);
    chk({tag, ".scoreValid"}, int'(scoreValid), esv);
    chk({tag, ".scoreValue"}, int'(scoreValue), esval);
  endtask

  task automatic idle_inputs();
    spawn = 1'b0; spawnX = '0; spawnY = '0; spawnType = '0;
    startOfFrame = 1'b0; collision = 1'b0; hookBusy = 1'b0;
    hookTipX = '0; hookTipY = '0; hookAtSurface = 1'b0;
  endtask

  initial begin
    //            sp  sx   sy  st sof col busy tx   ty  surf   ex   ey  et g pw sv sval
    tbl.push_back(mk(1, 100, 200, 2, 0, 0, 0,   0,   0, 0,   100, 200, 2, 0, 0, 0, 0));   // 0 spawn
    tbl.push_back(mk(0,   0,   0, 0, 0, 1, 0,   0,   0, 0,   100, 200, 2, 0, 0, 0, 0));   // 1 mid-frame hit
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 0,   100, 200, 2, 1, 2, 0, 0));   // 2 grab, no move yet
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0, 120, 150, 0,   104, 150, 2, 1, 2, 0, 0));   // 3 follow
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   5, 500, 0,     0, 448, 2, 1, 2, 0, 0));   // 4 saturate/clamp
    tbl.push_back(mk(1,  10,  10, 1, 0, 0, 0,   0,   0, 0,     0, 448, 2, 1, 2, 0, 0));   // 5 spawn ignored
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0, 300, 300, 1,     0, 448, 2, 0, 0, 1, 100)); // 6 collect type 2
    tbl.push_back(mk(0,   0,   0, 0, 0, 0, 0,   0,   0, 0,     0, 448, 0, 0, 0, 0, 0));   // 7 empty
    tbl.push_back(mk(1, 700, 460, 3, 0, 0, 0,   0,   0, 0,   608, 448, 3, 0, 0, 0, 0));   // 8 clamped spawn
    tbl.push_back(mk(0,   0,   0, 0, 1, 1, 1,   0,   0, 0,   608, 448, 3, 0, 0, 0, 0));   // 9 hook busy
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 0,   608, 448, 3, 0, 0, 0, 0));   // 10 flag was cleared
    tbl.push_back(mk(0,   0,   0, 0, 0, 1, 0,   0,   0, 0,   608, 448, 3, 0, 0, 0, 0));   // 11 new hit
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 0,   608, 448, 3, 1, 3, 0, 0));   // 12 grab
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0, 300, 100, 0,   284, 100, 3, 1, 3, 0, 0));   // 13 follow
    tbl.push_back(mk(0,   0,   0, 0, 0, 0, 0,   0,   0, 1,   284, 100, 3, 1, 3, 0, 0));   // 14 surface w/o frame
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 1,   284, 100, 3, 0, 0, 1, 250)); // 15 collect type 3
    tbl.push_back(mk(0,   0,   0, 0, 0, 0, 0,   0,   0, 0,   284, 100, 0, 0, 0, 0, 0));   // 16 single pulse
    tbl.push_back(mk(0,   0,   0, 0, 1, 1, 0,   0,   0, 1,   284, 100, 0, 0, 0, 0, 0));   // 17 empty ignores all
    tbl.push_back(mk(1,  50,  60, 4, 0, 0, 0,   0,   0, 0,    50,  60, 4, 0, 0, 0, 0));   // 18 spawn rock
    tbl.push_back(mk(0,   0,   0, 0, 0, 1, 0,   0,   0, 0,    50,  60, 4, 0, 0, 0, 0));   // 19 hit
    tbl.push_back(mk(1,  70,  80, 1, 1, 1, 0,   0,   0, 0,    70,  80, 1, 0, 0, 0, 0));   // 20 spawn beats frame
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 0,    70,  80, 1, 0, 0, 0, 0));   // 21 history dropped
    tbl.push_back(mk(0,   0,   0, 0, 1, 1, 0,   0,   0, 0,    70,  80, 1, 1, 1, 0, 0));   // 22 same-cycle hit
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 1,    70,  80, 1, 0, 0, 1, 50));  // 23 collect type 1
    tbl.push_back(mk(0,   0,   0, 0, 0, 0, 0,   0,   0, 0,    70,  80, 0, 0, 0, 0, 0));   // 24
    tbl.push_back(mk(1,  32,  32, 4, 0, 0, 0,   0,   0, 0,    32,  32, 4, 0, 0, 0, 0));   // 25
    tbl.push_back(mk(0,   0,   0, 0, 1, 1, 0,   0,   0, 0,    32,  32, 4, 1, 4, 0, 0));   // 26 rock weight
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 1,    32,  32, 4, 0, 0, 1, 10));  // 27 collect rock
    tbl.push_back(mk(0,   0,   0, 0, 0, 0, 0,   0,   0, 0,    32,  32, 0, 0, 0, 0, 0));   // 28
    tbl.push_back(mk(1,   1,   2, 0, 0, 0, 0,   0,   0, 0,     1,   2, 0, 0, 0, 0, 0));   // 29 filler spawn
    tbl.push_back(mk(0,   0,   0, 0, 1, 1, 0,   0,   0, 0,     1,   2, 0, 0, 0, 0, 0));   // 30 stays empty
    tbl.push_back(mk(1, 200, 100, 3, 0, 0, 0,   0,   0, 0,   200, 100, 3, 0, 0, 0, 0));   // 31
    tbl.push_back(mk(0,   0,   0, 0, 0, 1, 0,   0,   0, 0,   200, 100, 3, 0, 0, 0, 0));   // 32
    tbl.push_back(mk(0,   0,   0, 0, 1, 0, 0,   0,   0, 0,   200, 100, 3, 1, 3, 0, 0));   // 33 grabbed

    // Reset state
    idle_inputs();
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    resetN = 1'b1;

    // Table-driven cycles
    for (int i = 0; i < tbl.size(); i++) begin
      spawn = tbl[i].sp; spawnX = tbl[i].sx; spawnY = tbl[i].sy; spawnType = tbl[i].st;
      startOfFrame = tbl[i].sof; collision = tbl[i].col; hookBusy = tbl[i].busy;
      hookTipX = tbl[i].tx; hookTipY = tbl[i].ty; hookAtSurface = tbl[i].surf;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), int'(tbl[i].ex), int'(tbl[i].ey), int'(tbl[i].et),
              int'(tbl[i].eg), int'(tbl[i].epw), int'(tbl[i].esv), int'(tbl[i].esval));
    end

    // Reset mid-GRABBED: outputs clear without a clock edge.
    idle_inputs();
    #2;
    resetN = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);

    // Frame with hook at surface while reset is held, then after release: no score pulse.
    startOfFrame = 1'b1; hookAtSurface = 1'b1; hookTipX = 11'd300; hookTipY = 11'd300;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rst_hold%0d.scoreValid", k), int'(scoreValid), 0);
      chk($sformatf("rst_hold%0d.grabbed", k), int'(grabbed), 0);
    end
    resetN = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk_all($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0, 0, 0);
    end

    idle_inputs();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
